// File: rtl/vliw_fetch_issue_if.sv
// Fetch/issue bus bundle for vliw_fetch_issue.
// Groups the instruction-memory port, the redirect request and the issue handshake.
//   master : the fetch/issue stage (drives imem_req/addr, issue_*, fifo_count)
//   slave  : the surrounding environment (imem, branch unit, execute stage)
interface vliw_fetch_issue_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Instruction memory port
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    // Redirect (branch/jump) request
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    // Issue handshake and pre-split slot fields
    logic              issue_valid;
    logic              issue_ready;
    logic [31:0]       issue_bundle;
    logic [ADDR_W-1:0] issue_pc;
    logic [7:0]        issue_op1;
    logic [7:0]        issue_op2;
    logic [3:0]        issue_rd1;
    logic [3:0]        issue_rd2;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output issue_valid,
        input  issue_ready,
        output issue_bundle, issue_pc, issue_op1, issue_op2, issue_rd1, issue_rd2,
        output fifo_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  issue_valid,
        output issue_ready,
        input  issue_bundle, issue_pc, issue_op1, issue_op2, issue_rd1, issue_rd2,
        input  fifo_count
    );
endinterface

// File: rtl/vliw_fetch_issue.sv
// vliw_fetch_issue: fetch/issue stage for the 2-slot VLIW core.
// Requests one bundle per cycle from a 1-cycle-latency imem while credit remains
// (buffered + in-flight < DEPTH), buffers responses with their PC in a prefetch FIFO
// and presents the head over a valid/ready handshake with slot fields pre-split.
// A redirect flushes the FIFO and the in-flight response and restarts at redirect_pc.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous reset, active-high, overrides every other input
//   bus  : vliw_fetch_issue_if.master (imem port, redirect, issue handshake, fifo_count)
module vliw_fetch_issue #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    vliw_fetch_issue_if.master     bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    // Architectural state
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Prefetch storage (data path, no reset needed)
    logic [31:0]       fifo_bundle [DEPTH];
    logic [ADDR_W-1:0] fifo_pc     [DEPTH];

    // Combinational control
    logic              credit_ok;
    logic              not_empty;
    logic              req;
    logic              valid;
    logic              push;
    logic              pop;
    logic [31:0]       head_bundle;
    logic [ADDR_W-1:0] head_pc;

    // Credit, handshake and head-of-FIFO decode
    always_comb begin
        credit_ok   = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
        not_empty   = (count != '0);
        req         = !rst && !bus.redirect_valid && credit_ok;
        valid       = not_empty && !bus.redirect_valid;
        // A response arriving in a redirect cycle is dropped: the FIFO is cleared at that edge.
        push        = inflight && !bus.redirect_valid;
        pop         = valid && bus.issue_ready;
        head_bundle = '0;
        head_pc     = '0;
        if (not_empty) begin
            head_bundle = fifo_bundle[rd_ptr];
            head_pc     = fifo_pc[rd_ptr];
        end
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc;
    assign bus.issue_valid  = valid;
    assign bus.issue_bundle = head_bundle;
    assign bus.issue_pc     = head_pc;
    assign bus.issue_op1    = head_bundle[31:24];
    assign bus.issue_op2    = head_bundle[23:16];
    assign bus.issue_rd1    = head_bundle[15:12];
    assign bus.issue_rd2    = head_bundle[11:8];
    assign bus.fifo_count   = count;

    // PC, in-flight tracking and FIFO occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= ADDR_W'(RESET_PC);
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= req;
            if (req) begin
                req_pc <= pc;
                pc     <= pc + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response capture; credit guarantees the written slot is never the live head
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_bundle[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]     <= req_pc;
        end
    end

endmodule
